// File: rtl/arb_mux_pkg.sv
// Shared types and the round-robin search used by arb_mux_stage.
// Grant search covers up to 256 requesters.
package arb_mux_pkg;

   localparam int COUNT_W = 32;
   localparam int RR_MAX  = 256;

   typedef struct packed {
      logic       any;
      logic [7:0] idx;
   } rr_t;

   // First set bit at or after ptr, scanning upward and wrapping modulo n.
   function automatic rr_t rr_search(
      input logic [RR_MAX-1:0] valid,
      input int                n,
      input int                ptr
   );
      rr_t r;
      int  j;
      r = '0;
      j = 0;
      for (int i = 0; i < RR_MAX; i++) begin
         if (!r.any && i < n) begin
            j = (ptr + i) % n;
            if (valid[j[7:0]]) begin
               r.any = 1'b1;
               r.idx = 8'(j);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/Mux.sv
// Plain N:1 word multiplexer over a flat bus.
// Input i lives at bits [i*WIDTH +: WIDTH].
module Mux #(
   parameter int WIDTH = 3,
   parameter int SIZE  = 3
) (
   input  logic [SIZE-1:0]              sel,
   input  logic [(2**SIZE)*WIDTH-1:0]   in,
   output logic [WIDTH-1:0]             out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < 2**SIZE; i++) begin
         if (sel == SIZE'(i)) out = in[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/arb_mux_stage.sv
// Round-robin arbiter feeding a one-deep registered output stage.
// Define ARB_MUX_STAGE_COUNT_EN to add the xfer_count output.
module arb_mux_stage
   import arb_mux_pkg::*;
#(
   parameter  int WIDTH = 3,
   parameter  int SIZE  = 3,
   localparam int N     = 2**SIZE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [N*WIDTH-1:0]   in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out,
   output logic [SIZE-1:0]      out_sel
`ifdef ARB_MUX_STAGE_COUNT_EN
   ,
   output logic [COUNT_W-1:0]   xfer_count
`endif
);

   logic [SIZE-1:0]  rr_ptr;
   logic [SIZE-1:0]  grant;
   logic [WIDTH-1:0] mux_out;
   logic             load;
   logic             in_xfer;
   logic             out_xfer;
   rr_t              rr;
   logic             unused_rr;

   assign load     = !out_valid || out_ready;
   assign rr       = rr_search(RR_MAX'(in_valid), N, int'(rr_ptr));
   assign grant    = rr.idx[SIZE-1:0];
   assign unused_rr = ^rr.idx[7:SIZE];

   // Grant depends only on valids and pointer, never on data.
   assign in_ready = (rr.any && load && !reset) ? (N'(1) << grant) : '0;
   assign in_xfer  = |(in_valid & in_ready);
   assign out_xfer = out_valid && out_ready;

   Mux #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
   ) u_mux (
      .sel (grant),
      .in  (in),
      .out (mux_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         out       <= mux_out;
         out_sel   <= grant;
         rr_ptr    <= grant + SIZE'(1);
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ARB_MUX_STAGE_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) xfer_count <= '0;
      else if (out_xfer) xfer_count <= xfer_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_arb_mux_stage.sv
// Directed bench for arb_mux_stage at WIDTH=3, SIZE=3.
// Table of single-cycle vectors plus reset, round-robin and wrap sequences.
module tb_arb_mux_stage;

   localparam int WIDTH = 3;
   localparam int SIZE  = 3;
   localparam int N     = 8;

   logic             clk;
   logic             reset;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [N*WIDTH-1:0] in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic [SIZE-1:0]  out_sel;
`ifdef ARB_MUX_STAGE_COUNT_EN
   logic [31:0]      xfer_count;
`endif

   int n_chk;
   int n_fail;

   arb_mux_stage #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_sel   (out_sel)
`ifdef ARB_MUX_STAGE_COUNT_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]       iv;
      logic               ordy;
      logic [N*WIDTH-1:0] din;
      logic [N-1:0]       x_rdy;
      logic               x_ov;
      logic [WIDTH-1:0]   x_out;
      logic [SIZE-1:0]    x_sel;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[12];
   logic [N*WIDTH-1:0] d_id;
   logic [N*WIDTH-1:0] d_inv;
   logic [N*WIDTH-1:0] d_rr;
   logic [WIDTH-1:0]   pat[4];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < N; i++) begin
         d_id[i*WIDTH +: WIDTH]  = WIDTH'(i);
         d_inv[i*WIDTH +: WIDTH] = WIDTH'(7 - i);
      end
      pat[0] = 3'd1; pat[1] = 3'd2; pat[2] = 3'd4; pat[3] = 3'd6;
      for (int i = 0; i < N; i++) d_rr[i*WIDTH +: WIDTH] = pat[i % 4];

      //            iv     ordy din    x_rdy  ov  out   sel
      vecs[0]  = '{8'h08, 1'b1, d_id,  8'h08, 1, 3'd3, 3'd3};
      vecs[1]  = '{8'h00, 1'b0, d_id,  8'h00, 1, 3'd3, 3'd3};
      vecs[2]  = '{8'h01, 1'b0, d_id,  8'h00, 1, 3'd3, 3'd3};
      vecs[3]  = '{8'h01, 1'b1, d_id,  8'h01, 1, 3'd0, 3'd0};
      vecs[4]  = '{8'h00, 1'b1, d_id,  8'h00, 0, 3'd0, 3'd0};
      vecs[5]  = '{8'h81, 1'b0, d_id,  8'h80, 1, 3'd7, 3'd7};
      vecs[6]  = '{8'h81, 1'b1, d_id,  8'h01, 1, 3'd0, 3'd0};
      vecs[7]  = '{8'hFF, 1'b1, d_inv, 8'h02, 1, 3'd6, 3'd1};
      vecs[8]  = '{8'h24, 1'b1, d_inv, 8'h04, 1, 3'd5, 3'd2};
      vecs[9]  = '{8'h24, 1'b1, d_inv, 8'h20, 1, 3'd2, 3'd5};
      vecs[10] = '{8'h24, 1'b0, d_inv, 8'h00, 1, 3'd2, 3'd5};
      vecs[11] = '{8'h00, 1'b1, d_inv, 8'h00, 0, 3'd2, 3'd5};

      // Reset state with requests pending
      reset     = 1'b1;
      in_valid  = 8'hFF;
      in        = d_id;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out",       32'(out),       32'd0);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_rr_ptr",    32'(dut.rr_ptr), 32'd0);
      in_valid = '0;
      #2 reset = 1'b0;
      tick();
      chk("rr_ptr_after_single", 32'(dut.rr_ptr), 32'd0);

      foreach (vecs[k]) begin
         in_valid  = vecs[k].iv;
         out_ready = vecs[k].ordy;
         in        = vecs[k].din;
         #1;
         chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].x_rdy));
         tick();
         chk($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].x_ov));
         chk($sformatf("v%0d_out", k),       32'(out),       32'(vecs[k].x_out));
         chk($sformatf("v%0d_out_sel", k),   32'(out_sel),   32'(vecs[k].x_sel));
         if (k == 0) chk("v0_rr_ptr", 32'(dut.rr_ptr), 32'd4);
      end

      // Asynchronous reset while a held word is waiting
      in_valid  = 8'h08;
      out_ready = 1'b0;
      in        = d_id;
      tick();
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_out",       32'(out),       32'd3);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out",       32'(out),       32'd0);
      chk("mid_rst_out_sel",   32'(out_sel),   32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
      in_valid = '0;
      #2 reset = 1'b0;

      // All requesters held: one grant per cycle, in index order
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      in        = d_rr;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("rr%0d_sel", k), 32'(out_sel), 32'(k % 8));
         chk($sformatf("rr%0d_out", k), 32'(out),     32'(pat[k % 4]));
         chk($sformatf("rr%0d_ov", k),  32'(out_valid), 32'd1);
      end

      // Pointer wrap from 7 back to 0
      in_valid = 8'h40;
      tick();
      chk("wrap_pre_sel", 32'(out_sel),    32'd6);
      chk("wrap_ptr7",    32'(dut.rr_ptr), 32'd7);
      in_valid = 8'h81;
      #1;
      chk("wrap_rdy7", 32'(in_ready), 32'h80);
      tick();
      chk("wrap_sel7", 32'(out_sel), 32'd7);
      chk("wrap_out7", 32'(out),     32'd6);
      tick();
      chk("wrap_sel0", 32'(out_sel), 32'd0);
      chk("wrap_out0", 32'(out),     32'd1);
      chk("wrap_ptr1", 32'(dut.rr_ptr), 32'd1);
      in_valid = '0;
      tick();
      chk("drain_ov", 32'(out_valid), 32'd0);

`ifdef ARB_MUX_STAGE_COUNT_EN
      reset = 1'b1;
      #1;
      chk("cnt_rst", xfer_count, 32'd0);
      #2 reset = 1'b0;
      in_valid  = 8'h01;
      out_ready = 1'b1;
      repeat (10) tick();
      in_valid = '0;
      tick();
      chk("cnt_10", xfer_count, 32'd10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_mux_stage.md
ARB_MUX_STAGE -- requirements
Module: arb_mux_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 3, data bits per input.
REQ-002 SHALL have parameter SIZE, default 3, select bits; N = 2**SIZE inputs.
REQ-003 SHALL have port clk, input, 1, single clock; all state on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, N, per-input request valid.
REQ-006 SHALL have port in_ready, output, N, per-input accept; at most one bit high.
REQ-007 SHALL have port in, input, N*WIDTH, flat data bus; input i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port out_valid, output, 1, output register holds data.
REQ-009 SHALL have port out_ready, input, 1, downstream accept.
REQ-010 SHALL have port out, output, WIDTH, registered selected data.
REQ-011 SHALL have port out_sel, output, SIZE, index of the input that supplied out.

Function
REQ-012 SHALL transfer input i when in_valid[i] && in_ready[i]; SHALL transfer output when out_valid && out_ready.
REQ-013 SHALL set load = !out_valid || out_ready; in_ready SHALL be all-zero when load is low.
REQ-014 SHALL grant the first valid input at or after rr_ptr, searching upward modulo N, wrapping N-1 -> 0.
REQ-015 SHALL drive in_ready[grant] = load when any in_valid bit is set; otherwise in_ready = 0.
REQ-016 SHALL register in[grant], grant and out_valid=1 on an input transfer; latency is 1 cycle from input transfer to out_valid.
REQ-017 SHALL clear out_valid on an output transfer with no simultaneous input transfer.
REQ-018 SHALL, on a simultaneous output and input transfer, replace the output with the new data, keeping out_valid=1 (full throughput, one word per cycle).
REQ-019 SHALL hold out, out_sel and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL set rr_ptr = (grant+1) mod N on each input transfer; SHALL leave it unchanged otherwise.
REQ-021 SHALL keep the grant combinational from in_valid and rr_ptr; in_ready SHALL NOT depend on in data.
REQ-022 SHALL not block a requester whose in_valid is held: it is granted within N load cycles.

Reset
REQ-023 SHALL on reset force out_valid=0, out=0, out_sel=0, rr_ptr=0, and count=0 when present, immediately and asynchronously.
REQ-024 SHALL discard any held output on reset mid-operation; in_ready SHALL be 0 while reset is high.

Configuration
REQ-025 SHALL, with ARB_MUX_STAGE_COUNT_EN defined, add output xfer_count[31:0], reset 0, incremented by 1 per output transfer, wrapping 0xFFFFFFFF -> 0.
REQ-026 SHALL, without ARB_MUX_STAGE_COUNT_EN, omit the xfer_count port and counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL place in package arb_mux_pkg the round-robin search function (valid vector, pointer -> grant index, any-valid flag) and the count width constant 32.
REQ-028 SHALL select data through one instance of the existing Mux (WIDTH, SIZE), sel = grant; no other sub-module.

Verification
REQ-029 Reset: assert reset mid-transfer with out_valid=1 -> out_valid=0, out=0, out_sel=0 in the same cycle, in_ready=0.
REQ-030 Single requester: WIDTH=3, SIZE=3, in_valid=8'h08, input 3 = 3'b011, out_ready=1 -> next cycle out=3'b011, out_sel=3, rr_ptr=4.
REQ-031 Round robin: in_valid=8'hFF held, out_ready=1, in = {d,c,b,a,d,c,b,a} -> out_sel sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-032 Backpressure: out_valid=1, out_ready=0 for 5 cycles, in_valid=8'h01 -> in_ready=0, out and out_sel unchanged; release -> new word loaded same edge.
REQ-033 Wrap: rr_ptr=7, in_valid=8'h81 -> grant 7, then grant 0.
REQ-034 Counter (ARB_MUX_STAGE_COUNT_EN): 10 output transfers -> xfer_count=10; build without macro -> compiles with no xfer_count port.
